// File: rtl/async_fifo_rd_streamer_if.sv
// Read-side bundle: FIFO pull interface plus valid/ready output stream.
interface async_fifo_rd_streamer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    // Streamer side: pulls from the FIFO, pushes the stream.
    modport master (
        output fifo_rd_en, m_data, m_valid, m_last,
        input  fifo_rd_data, fifo_empty, m_ready
    );

    // Environment side: the FIFO and the stream consumer.
    modport slave (
        input  fifo_rd_en, m_data, m_valid, m_last,
        output fifo_rd_data, fifo_empty, m_ready
    );
endinterface

// File: rtl/async_fifo_rd_streamer.sv
// Read-side adapter for async_fifo: hides the one-cycle read latency behind a
// small prefetch ring so the stream runs at one beat per cycle.
module async_fifo_rd_streamer #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned BUF_DEPTH  = 2,
    parameter  int unsigned PKT_LEN    = 0,
    parameter  int unsigned CNT_WIDTH  = 16,
    localparam int unsigned OCC_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    async_fifo_rd_streamer_if.master         bus,
    output logic [OCC_W-1:0]                 occupancy,
    output logic [CNT_WIDTH-1:0]             m_beats
);

    localparam int unsigned PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned IDX_LAST = (PKT_LEN > 0) ? PKT_LEN - 1 : 0;
    localparam int unsigned CMP_W    = OCC_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  beats_q, beats_d;

    logic                  valid_c;
    logic                  pop_c;
    logic                  rd_en_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue decision, ring write on capture, ring read on pop, counters.
    always_comb begin
        valid_c    = (occ_q != '0);
        pop_c      = valid_c & bus.m_ready;
        // Count the word already in flight so the ring can never overflow.
        rd_en_c    = !rst && !bus.fifo_empty &&
                     ((CMP_W'(occ_q) + CMP_W'(inflight_q)) <
                      (CMP_W'(BUF_DEPTH) + CMP_W'(pop_c)));

        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        idx_d      = idx_q;
        beats_d    = beats_q;
        inflight_d = rd_en_c;
        occ_d      = occ_q + OCC_W'(inflight_q) - OCC_W'(pop_c);

        if (inflight_q) begin
            mem_d[tail_q] = bus.fifo_rd_data;
            tail_d        = ptr_inc(tail_q);
        end

        if (pop_c) begin
            head_d  = ptr_inc(head_q);
            beats_d = beats_q + CNT_WIDTH'(1);
            if (PKT_LEN != 0) begin
                idx_d = (idx_q == IDX_W'(IDX_LAST)) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // State register; reset also drops any word arriving from a pre-reset read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            idx_q      <= '0;
            beats_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            idx_q      <= idx_d;
            beats_q    <= beats_d;
        end
    end

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_data     = mem_q[head_q];
    assign bus.m_valid    = valid_c;
    assign bus.m_last     = (PKT_LEN != 0) && (idx_q == IDX_W'(IDX_LAST));
    assign occupancy      = occ_q;
    assign m_beats        = beats_q;

endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// Directed bench for async_fifo_rd_streamer with a behavioural FIFO model.
module tb_async_fifo_rd_streamer;

    localparam int unsigned DW = 8;
    localparam int unsigned BD = 2;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned OW = $clog2(BD + 1);

    logic          clk;
    logic          rst;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] m_beats;

    int n_chk  = 0;
    int n_fail = 0;

    async_fifo_rd_streamer_if #(.DATA_WIDTH(DW)) bus ();

    async_fifo_rd_streamer #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .PKT_LEN    (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .occupancy (occupancy),
        .m_beats   (m_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: one cycle of read latency, empty when pointers meet.
    logic [DW-1:0] fmem [1024];
    int wr_ptr     = 0;
    int rd_ptr     = 0;
    int underflows = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                underflows <= underflows + 1;
            end else begin
                bus.fifo_rd_data <= fmem[rd_ptr];
                rd_ptr           <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [DW-1:0] v);
        fmem[wr_ptr] = v;
        wr_ptr       = wr_ptr + 1;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        bus.m_ready = 1'b0;
        push(8'h11);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_chk++;
            if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 ||
                occupancy !== '0 || m_beats !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: rd_en=%b valid=%b occ=%0d beats=%0d, want all 0",
                         i, bus.fifo_rd_en, bus.m_valid, occupancy, m_beats);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rst         = 1'b0;
                bus.m_ready = 1'b1;
            end
            #1;
            if (c == 0) begin
                n_chk++;
                if (bus.fifo_rd_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_first_rd_en: got %b want 1", bus.fifo_rd_en);
                end
            end
            if (c == 2) begin
                n_chk++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11) begin
                    n_fail++;
                    $display("FAIL reset_first_word: valid=%b data=%0h want 1/11", bus.m_valid, bus.m_data);
                end
            end
            if (c == 3) begin
                n_chk++;
                if (bus.m_valid !== 1'b0 || m_beats !== 16'd1) begin
                    n_fail++;
                    $display("FAIL reset_first_drain: valid=%b beats=%0d want 0/1", bus.m_valid, m_beats);
                end
            end
        end
    endtask

    task automatic test_single;
        logic exp_en, exp_v;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) push(8'hAB);
            #1;
            exp_en = (c == 0);
            exp_v  = (c == 2);
            n_chk++;
            if (bus.fifo_rd_en !== exp_en || bus.m_valid !== exp_v) begin
                n_fail++;
                $display("FAIL single cyc%0d: rd_en=%b valid=%b want %b/%b",
                         c, bus.fifo_rd_en, bus.m_valid, exp_en, exp_v);
            end
            if (c == 2) begin
                n_chk++;
                if (bus.m_data !== 8'hAB) begin
                    n_fail++;
                    $display("FAIL single_data: got %0h want ab", bus.m_data);
                end
            end
        end
        n_chk++;
        if (m_beats !== 16'd2 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL single_end: beats=%0d occ=%0d want 2/0", m_beats, occupancy);
        end
    endtask

    task automatic test_throughput;
        logic exp_en, exp_v;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < 16; i++) push(DW'(i));
            end
            #1;
            exp_en = (c < 16);
            exp_v  = (c >= 2) && (c < 18);
            n_chk++;
            if (bus.fifo_rd_en !== exp_en || bus.m_valid !== exp_v) begin
                n_fail++;
                $display("FAIL thru cyc%0d: rd_en=%b valid=%b want %b/%b",
                         c, bus.fifo_rd_en, bus.m_valid, exp_en, exp_v);
            end
            if (exp_v) begin
                n_chk++;
                if (bus.m_data !== DW'(c - 2)) begin
                    n_fail++;
                    $display("FAIL thru_data cyc%0d: got %0h want %0h", c, bus.m_data, c - 2);
                end
            end
        end
        n_chk++;
        if (m_beats !== 16'd18) begin
            n_fail++;
            $display("FAIL thru_beats: got %0d want 18", m_beats);
        end
    endtask

    task automatic test_backpressure;
        int   en_cnt;
        logic exp_v;
        en_cnt = 0;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < 16; i++) push(DW'(i));
            end
            bus.m_ready = (c >= 10);
            #1;
            if (c < 10 && bus.fifo_rd_en === 1'b1) en_cnt++;
            if (c >= 2 && c < 10) begin
                n_chk++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc%0d: valid=%b data=%0h want 1/0", c, bus.m_valid, bus.m_data);
                end
            end
            if (c == 9) begin
                n_chk++;
                if (en_cnt != 2 || occupancy !== OW'(2)) begin
                    n_fail++;
                    $display("FAIL bp_fill: rd_en pulses=%0d occ=%0d want 2/2", en_cnt, occupancy);
                end
            end
            if (c >= 10) begin
                exp_v = (c < 26);
                n_chk++;
                if (bus.m_valid !== exp_v || (exp_v && bus.m_data !== DW'(c - 10))) begin
                    n_fail++;
                    $display("FAIL bp_drain cyc%0d: valid=%b data=%0h want %b/%0h",
                             c, bus.m_valid, bus.m_data, exp_v, c - 10);
                end
            end
        end
        n_chk++;
        if (m_beats !== 16'd34) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d want 34", m_beats);
        end
    endtask

    task automatic test_random_ready;
        logic [DW-1:0] exp_q [100];
        logic [DW-1:0] hold_data;
        logic          hold_last;
        logic          held;
        int            k;
        @(negedge clk);
        rst         = 1'b1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            exp_q[i] = DW'(i * 37 + 5);
            push(exp_q[i]);
        end
        k    = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 2000 && k < 100; cyc++) begin
            @(negedge clk);
            bus.m_ready = 1'($urandom_range(0, 1));
            #1;
            n_chk++;
            if (occupancy > OW'(BD)) begin
                n_fail++;
                $display("FAIL rnd_occ: got %0d want <= %0d", occupancy, BD);
            end
            if (held) begin
                n_chk++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== hold_data || bus.m_last !== hold_last) begin
                    n_fail++;
                    $display("FAIL rnd_stable: valid=%b data=%0h last=%b want 1/%0h/%b",
                             bus.m_valid, bus.m_data, bus.m_last, hold_data, hold_last);
                end
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                n_chk++;
                if (bus.m_data !== exp_q[k] || bus.m_last !== ((k % 4) == 3)) begin
                    n_fail++;
                    $display("FAIL rnd_beat%0d: data=%0h last=%b want %0h/%b",
                             k, bus.m_data, bus.m_last, exp_q[k], (k % 4) == 3);
                end
                k++;
                held = 1'b0;
            end else if (bus.m_valid === 1'b1) begin
                held      = 1'b1;
                hold_data = bus.m_data;
                hold_last = bus.m_last;
            end
        end
        n_chk++;
        if (k != 100) begin
            n_fail++;
            $display("FAIL rnd_timeout: beats seen %0d want 100", k);
        end
        @(negedge clk);
        bus.m_ready = 1'b1;
        #1;
        n_chk++;
        if (bus.m_valid !== 1'b0 || m_beats !== 16'd100) begin
            n_fail++;
            $display("FAIL rnd_end: valid=%b beats=%0d want 0/100", bus.m_valid, m_beats);
        end
    endtask

    task automatic test_reset_mid;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < 4; i++) push(8'hA0 + DW'(i));
            end
            rst = (c == 1);
            #1;
            if (c == 1) begin
                n_chk++;
                if (bus.fifo_rd_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_rst_rd_en: got %b want 0", bus.fifo_rd_en);
                end
            end
            if (c == 2) begin
                n_chk++;
                if (occupancy !== '0 || m_beats !== '0 || bus.m_valid !== 1'b0 || bus.fifo_rd_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_after_rst: occ=%0d beats=%0d valid=%b rd_en=%b want 0/0/0/1",
                             occupancy, m_beats, bus.m_valid, bus.fifo_rd_en);
                end
            end
            if (c == 3 || c == 7) begin
                n_chk++;
                if (bus.m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_idle cyc%0d: valid=%b want 0", c, bus.m_valid);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_chk++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA0 + DW'(c - 3)) begin
                    n_fail++;
                    $display("FAIL mid_data cyc%0d: valid=%b data=%0h want 1/%0h",
                             c, bus.m_valid, bus.m_data, 8'hA0 + c - 3);
                end
            end
        end
        n_chk++;
        if (m_beats !== 16'd3) begin
            n_fail++;
            $display("FAIL mid_beats: got %0d want 3", m_beats);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.m_ready = 1'b0;
        test_reset();
        test_single();
        test_throughput();
        test_backpressure();
        test_random_ready();
        test_reset_mid();
        n_chk++;
        if (underflows != 0) begin
            n_fail++;
            $display("FAIL rd_en_while_empty: got %0d reads want 0", underflows);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_streamer.md
Name: async_fifo_rd_streamer

Overview:
- Single-clock read-side adapter placed directly downstream of async_fifo, in the rd_clk domain.
- Drives the FIFO's rd_en/rd_data/empty pull interface, which has one cycle of read latency.
- Presents a valid/ready stream with full one-beat-per-cycle throughput, backed by a small prefetch buffer.
- Optionally marks packet boundaries with m_last every PKT_LEN beats.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- BUF_DEPTH, 2, prefetch buffer entries; minimum 2 for full throughput.
- PKT_LEN, 0, beats per packet for m_last generation; 0 disables m_last (held 0).
- CNT_WIDTH, 16, width of the beat counter and the m_beats output.

Ports:
- clk  in  1  stream clock; connects to the FIFO rd_clk.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag in this clock domain.
- m_data  out  DATA_WIDTH  stream data, head of the prefetch buffer.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  last beat of a packet.
- occupancy  out  $clog2(BUF_DEPTH+1)  entries currently held in the buffer.
- m_beats  out  CNT_WIDTH  count of accepted stream beats; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, occupancy=0, m_beats=0. Internal in-flight flag=0, packet beat index=0.
- Definitions:
  - pop = m_valid & m_ready.
  - inflight = 1 when fifo_rd_en was asserted in the previous cycle.
- Issue rule:
  - fifo_rd_en = !rst & !fifo_empty & ((occupancy + inflight - pop) < BUF_DEPTH).
  - fifo_rd_en is combinational from m_ready, fifo_empty and registered state.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Capture: when inflight=1, fifo_rd_data is written at the tail of the buffer on that clk edge.
- Buffer: circular, BUF_DEPTH entries, with head/tail pointers wrapping at BUF_DEPTH.
  - m_data = buffer[head]; m_valid = (occupancy != 0).
  - Next occupancy = occupancy + inflight - pop.
  - Simultaneous capture and pop in the same cycle leaves occupancy unchanged.
  - Overflow is impossible by the issue rule; the verifier asserts occupancy <= BUF_DEPTH.
- Latency:
  - A word written into an empty FIFO: m_valid rises 2 clk cycles after fifo_empty falls (rd_en cycle, then capture cycle).
  - Steady state: one beat per cycle while m_ready=1 and the FIFO is non-empty.
- Stream rules:
  - Once m_valid=1, m_data and m_last stay stable until pop.
  - m_valid does not drop without a pop.
- m_last:
  - Tracked by a packet beat index (0..PKT_LEN-1).
  - m_last = (PKT_LEN!=0) & (index == PKT_LEN-1).
  - On pop, index increments, and wraps to 0 after PKT_LEN-1.
- m_beats: increments by 1 on every pop.
- Backpressure: with m_ready=0, the buffer fills to BUF_DEPTH, then fifo_rd_en stays 0. No data is lost or reordered.
- FIFO drains to empty mid-stream: fifo_rd_en drops the same cycle fifo_empty=1. Buffered words still drain normally.
- Reset mid-operation:
  - All state clears on the next edge; an in-flight word arriving the cycle after rst is discarded.
  - The FIFO's read pointer has already advanced for that word. Loss is accepted; the system resets the FIFO together with this block.
- During rst=1, fifo_rd_en=0 regardless of fifo_empty.

Test Plan:
- Reset: hold rst 5 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, occupancy=0, m_beats=0 throughout; first fifo_rd_en on the cycle after rst falls.
- Single word: FIFO holds 8'hAB, m_ready=1 -> one fifo_rd_en pulse; m_valid for exactly 1 cycle with m_data=8'hAB, 2 cycles after rd_en; m_beats=1; occupancy returns to 0.
- Throughput: preload 16 words 0..15, m_ready=1 -> fifo_rd_en high 16 consecutive cycles; m_valid high 16 consecutive cycles; data 0..15 in order; m_beats=16.
- Backpressure: preload 16 words, m_ready=0 for 10 cycles -> exactly 2 rd_en pulses; occupancy=2; m_data=0 stable; then m_ready=1 drains 0..15 in order with no gaps after the first beat.
- Random m_ready (50%) over 100 words, PKT_LEN=4 -> all 100 words in order; m_last on beats 3,7,...,99 only; m_data/m_last stable while m_valid & !m_ready.
- Reset mid-stream: assert rst for 1 cycle while inflight=1 -> the in-flight word never appears on m_data; occupancy=0 and m_beats=0 after reset; subsequent words stream correctly.
